// File: rtl/fp_compare_pkg.sv
// Shared definitions for schedulers that front a pipelined FP compare unit.
// Op encodings, the tag that rides alongside each in-flight compare, and ID sizing.
package fp_compare_pkg;

  localparam logic [1:0] OP_LTE = 2'd0;
  localparam logic [1:0] OP_GTE = 2'd1;
  localparam logic [1:0] OP_GT  = 2'd2;
  localparam logic [1:0] OP_LT  = 2'd3;

  // Wide enough for up to 16 requesters; narrower IDs are zero-extended.
  localparam int TAG_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                inv;
  } tag_t;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// The pointer moves past the winner only when the grant is consumed (advance).
module rr_arbiter
  import fp_compare_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
      pos = (pos == IW'(N-1)) ? '0 : pos + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else if (advance && found)
      ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/fp_compare_scheduler.sv
// Shares one pipelined FP a<=b compare unit between NUM_REQ requesters.
// GTE/LT swap operands, GT/LT invert the result; a tag pipe routes results home.
module fp_compare_scheduler
  import fp_compare_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_a,
  input  logic [NUM_REQ-1:0][31:0]  req_b,
  input  logic [NUM_REQ-1:0][1:0]   req_op,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [NUM_REQ-1:0]        resp_result,
  output logic [31:0]               cmp_a,
  output logic [31:0]               cmp_b,
  input  logic                      cmp_q
);

  localparam int IW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic [1:0]         sel_op;
  logic               swap;
  tag_t               issue_tag;
  tag_t [LATENCY:0]   tag_pipe;
  tag_t               tail;
  logic [NUM_REQ-1:0] resp_valid_d;
  logic [NUM_REQ-1:0] resp_result_d;

  // No backpressure from the compare unit, so every grant is consumed.
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (1'b1),
    .grant   (grant),
    .idx     (gidx)
  );

  assign req_ready = reset ? grant : '0;

  always_comb begin
    sel_op          = req_op[gidx];
    swap            = (sel_op == OP_GTE) || (sel_op == OP_LT);
    issue_tag.valid = |grant;
    issue_tag.id    = TAG_ID_W'(gidx);
    issue_tag.inv   = (sel_op == OP_GT) || (sel_op == OP_LT);
  end

  // Operands hold while idle so the compare unit sees no toggling.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmp_a <= '0;
      cmp_b <= '0;
    end else if (|grant) begin
      cmp_a <= swap ? req_b[gidx] : req_a[gidx];
      cmp_b <= swap ? req_a[gidx] : req_b[gidx];
    end
  end

  // Stage 0 launches with cmp_a/cmp_b; stage LATENCY lines up with cmp_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int s = 1; s <= LATENCY; s++)
        tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign tail = tag_pipe[LATENCY];

  always_comb begin
    resp_valid_d  = '0;
    resp_result_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tail.valid && (tail.id == TAG_ID_W'(i))) begin
        resp_valid_d[i]  = 1'b1;
        resp_result_d[i] = cmp_q ^ tail.inv;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid  <= '0;
      resp_result <= '0;
    end else begin
      resp_valid  <= resp_valid_d;
      resp_result <= resp_result_d;
    end
  end

endmodule

// File: tb/tb_fp_compare_scheduler.sv
// Bench for fp_compare_scheduler with a behavioural compare unit and a
// per-requester scoreboard of expected results and issue cycles.
module tb_fp_compare_scheduler;
  import fp_compare_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][31:0]   req_a = '0;
  logic [NREQ-1:0][31:0]   req_b = '0;
  logic [NREQ-1:0][1:0]    req_op = '0;
  logic [NREQ-1:0]         resp_valid;
  logic [NREQ-1:0]         resp_result;
  logic [31:0]             cmp_a, cmp_b;
  logic                    cmp_q;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic res;
    int   cyc;
  } exp_t;

  exp_t sbq [NREQ][$];
  exp_t mon_e;

  fp_compare_scheduler #(.NUM_REQ(NREQ), .LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_q       (cmp_q)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Compare unit model: IEEE a<=b, false on NaN, -0 == +0.
  function automatic logic fp_le(input logic [31:0] a, input logic [31:0] b);
    logic na, nb;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (na || nb) return 1'b0;
    if (a[30:0] == 0 && b[30:0] == 0) return 1'b1;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] <= b[30:0];
    return a[30:0] >= b[30:0];
  endfunction

  logic cu_pipe [LAT];
  always @(posedge clock) begin
    cu_pipe[0] <= fp_le(cmp_a, cmp_b);
    for (int k = 1; k < LAT; k++) cu_pipe[k] <= cu_pipe[k-1];
  end
  assign cmp_q = cu_pipe[LAT-1];

  // Scoreboard model uses an order-preserving integer key instead.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    logic [31:0] y;
    y = (x[30:0] == 0) ? 32'h0 : x;
    return y[31] ? ~y : (y ^ 32'h8000_0000);
  endfunction

  function automatic logic isnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic logic exp_res(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op);
    logic le_ab, le_ba;
    le_ab = !isnan(a) && !isnan(b) && (fkey(a) <= fkey(b));
    le_ba = !isnan(a) && !isnan(b) && (fkey(b) <= fkey(a));
    case (op)
      2'd0:    return le_ab;
      2'd1:    return le_ba;
      2'd2:    return !le_ab;
      default: return !le_ba;
    endcase
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: pops on responses, pushes on handshakes, flushes on reset.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) sbq[i].delete();
    end else begin
      checks++;
      if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != 0)) begin
        failures++;
        $display("FAIL ready_shape cyc=%0d ready=%b valid=%b", cyc, req_ready, req_valid);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i]) begin
          checks++;
          if (sbq[i].size() == 0) begin
            failures++;
            $display("FAIL extra_resp req=%0d cyc=%0d", i, cyc);
          end else begin
            mon_e = sbq[i].pop_front();
            if (resp_result[i] !== mon_e.res || cyc != mon_e.cyc + LAT + 2) begin
              failures++;
              $display("FAIL sb_resp req=%0d got=%b@%0d exp=%b@%0d", i, resp_result[i],
                       cyc, mon_e.res, mon_e.cyc + LAT + 2);
            end
          end
        end
        if (req_valid[i] && req_ready[i])
          sbq[i].push_back('{exp_res(req_a[i], req_b[i], req_op[i]), cyc});
      end
    end
  end

  task automatic idle(input int n);
    @(posedge clock); #1;
    req_valid = '0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue_wait(input int r, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic expv, input string nm);
    int n;
    @(posedge clock); #1;
    req_valid = NREQ'(1) << r;
    req_op[r] = op; req_a[r] = a; req_b[r] = b;
    @(negedge clock);
    checks++;
    if (req_ready !== (NREQ'(1) << r)) begin
      failures++;
      $display("FAIL %s_ready got=%b exp=%b", nm, req_ready, NREQ'(1) << r);
    end
    @(posedge clock); #1;
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid[r] && n < 20);
    checks++;
    if (resp_valid !== (NREQ'(1) << r) || resp_result[r] !== expv || n != LAT + 2) begin
      failures++;
      $display("FAIL %s got valid=%b res=%b lat=%0d exp valid=%b res=%b lat=%0d", nm,
               resp_valid, resp_result[r], n, NREQ'(1) << r, expv, LAT + 2);
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    repeat (2) @(negedge clock);
    checks++;
    if (req_ready !== '0 || resp_valid !== '0 || resp_result !== '0 ||
        cmp_a !== 32'h0 || cmp_b !== 32'h0) begin
      failures++;
      $display("FAIL reset_state ready=%b rv=%b rr=%b a=%h b=%h", req_ready, resp_valid,
               resp_result, cmp_a, cmp_b);
    end
    req_valid = 4'b0100;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=0100", req_ready);
    end
    req_valid = '0;
    idle(2);
  endtask

  task automatic test_single();
    issue_wait(2, OP_LTE, 32'h3F80_0000, 32'h4000_0000, 1'b1, "single_lte");
  endtask

  task automatic test_ops();
    issue_wait(0, OP_LTE, 32'h4040_0000, 32'h4040_0000, 1'b1, "op_lte_eq");
    issue_wait(0, OP_GTE, 32'h4040_0000, 32'h4040_0000, 1'b1, "op_gte_eq");
    issue_wait(0, OP_GT,  32'h4040_0000, 32'h4040_0000, 1'b0, "op_gt_eq");
    issue_wait(0, OP_LT,  32'h4040_0000, 32'h4040_0000, 1'b0, "op_lt_eq");
    issue_wait(0, OP_GT,  32'h7FC0_0000, 32'h3F80_0000, 1'b1, "op_gt_nan");
    issue_wait(0, OP_LT,  32'h7FC0_0000, 32'h3F80_0000, 1'b1, "op_lt_nan");
    issue_wait(1, OP_GT,  32'h4000_0000, 32'hBF80_0000, 1'b1, "op_gt_pos_neg");
    issue_wait(3, OP_LT,  32'h8000_0000, 32'h0000_0000, 1'b0, "op_lt_zeros");
  endtask

  task automatic test_fairness();
    int g;
    issue_wait(3, OP_LTE, 32'h0, 32'h0, 1'b1, "fair_setup");
    @(posedge clock); #1;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_op[i] = 2'($urandom_range(0, 3));
        req_a[i]  = $urandom;
        req_b[i]  = $urandom;
      end
      @(negedge clock);
      g = oh_idx(req_ready);
      checks++;
      if (g != k % NREQ) begin
        failures++;
        $display("FAIL fair_grant k=%0d got=%0d exp=%0d", k, g, k % NREQ);
      end
      @(posedge clock); #1;
    end
    idle(LAT + 4);
  endtask

  task automatic test_back_to_back_skip();
    int g;
    int expg [3] = '{3, 1, 3};
    issue_wait(1, OP_GTE, 32'h3F80_0000, 32'h3F80_0000, 1'b1, "skip_setup");
    @(posedge clock); #1;
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      g = oh_idx(req_ready);
      checks++;
      if (g != expg[k]) begin
        failures++;
        $display("FAIL skip_grant k=%0d got=%0d exp=%0d", k, g, expg[k]);
      end
      @(posedge clock); #1;
    end
    idle(LAT + 4);
  endtask

  task automatic test_reset_midflight();
    int pulses = 0;
    for (int r = 0; r < 3; r++) begin
      @(posedge clock); #1;
      req_valid = NREQ'(1) << r;
      req_op[r] = OP_LTE; req_a[r] = 32'h3F80_0000; req_b[r] = 32'h4000_0000;
    end
    @(posedge clock); #1;
    req_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      if (resp_valid != 0) pulses++;
    end
    @(posedge clock); #1;
    reset = 1'b1;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clock);
      if (resp_valid != 0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_flush pulses=%0d exp=0", pulses);
    end
    @(posedge clock); #1;
    req_valid = '1;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
    end
    idle(LAT + 4);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] tbl [8] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                             32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001};
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  task automatic test_soak();
    for (int c = 0; c < 10000; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        req_op[i]    = 2'($urandom_range(0, 3));
        req_a[i]     = pick();
        req_b[i]     = ($urandom_range(0, 3) == 0) ? req_a[i] : pick();
      end
    end
    idle(LAT + 6);
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        failures++;
        $display("FAIL soak_lost req=%0d pending=%0d exp=0", i, sbq[i].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_fairness();
    test_back_to_back_skip();
    test_reset_midflight();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
